alarm_ring: RTL and testbench
=============================

// Module: alarm_ring
// PURPOSE
// Alarm trigger and ring controller. Sits directly downstream of the alarm-time
//   set stage and the running time counter.
// Compares the current BCD time (hh:mm) with the stored alarm time (hh:mm).
// On a new match it rings the buzzer for a bounded time, with stop and snooze.
// Feeds the buzzer pin and the ringing/snooze status LEDs.
// PARAMETERS
// RING_SECS   60     seconds of ringing before auto-off (>=1)
// SNOOZE_MIN  5      snooze length in minutes; counted as SNOOZE_MIN*60 ticks (>=1)
// TONE_DIV    25000  clk cycles per buzz half-period (>=1)
// PORTS
// clk          in   1  system clock; all state on rising edge
// rst_n        in   1  asynchronous active-low reset
// tick_1hz     in   1  one-clk-wide pulse, once per second
// alarm_en     in   1  alarm armed; level
// cur_hour1    in   4  current time hour digit 1, BCD
// cur_hour2    in   4  current time hour digit 2, BCD
// cur_min1     in   4  current time minute digit 1, BCD
// cur_min2     in   4  current time minute digit 2, BCD
// alm_hour1    in   4  alarm hour digit 1, BCD (from alarm set stage)
// alm_hour2    in   4  alarm hour digit 2, BCD
// alm_min1     in   4  alarm minute digit 1, BCD
// alm_min2     in   4  alarm minute digit 2, BCD
// stop         in   1  one-clk pulse (debounced key): silence and disarm this event
// snooze       in   1  one-clk pulse (debounced key): pause ringing for SNOOZE_MIN
// ringing      out  1  high while in RING
// snoozing     out  1  high while in SNOOZE
// buzz         out  1  square-wave tone while in RING, else 0
// BEHAVIOUR
// - Reset (rst_n=0, async): state=IDLE, ringing=0, snoozing=0, buzz=0,
//   all counters=0, match_q=1. match_q=1 prevents a spurious trigger when
//   time and alarm both come out of reset at 00:00.
// - match = all four digit pairs equal (pure 4-bit compare, no BCD validation).
//   match_q <= match every clk.
// - trigger = match & ~match_q & alarm_en: one trigger per matching minute.
// - Trigger on edge N -> state=RING and ringing=1 after edge N (1-cycle latency).
//   ring_cnt=0, tone_cnt=0.
// - FSM states IDLE, RING, SNOOZE; all outputs decoded from registered state/regs.
//   IDLE  : trigger -> RING.
//   RING  : stop -> IDLE.
//           else snooze -> SNOOZE, snz_cnt=SNOOZE_MIN*60.
//           else on tick_1hz: ring_cnt++; when ring_cnt==RING_SECS-1 -> IDLE.
//   SNOOZE: stop -> IDLE.
//           else on tick_1hz: snz_cnt--; when snz_cnt==1 -> RING, ring_cnt=0, tone_cnt=0.
// - alarm_en=0 in any state -> IDLE on the next edge (highest priority after reset).
// - Priority: reset > alarm_en low > stop > snooze > tick.
// - trigger while in RING or SNOOZE is ignored; snooze while in SNOOZE is ignored.
// - Buzz tone: in RING, tone_cnt counts clk 0..TONE_DIV-1; buzz toggles at
//   TONE_DIV-1, then tone_cnt wraps to 0. First toggle comes TONE_DIV cycles
//   after RING entry. Leaving RING clears buzz and tone_cnt on the same edge.
// - Widths: ring_cnt $clog2(RING_SECS+1), snz_cnt $clog2(SNOOZE_MIN*60+1),
//   tone_cnt $clog2(TONE_DIV+1). No counter may wrap outside the rules above.
// - Alarm time changed while ringing: no effect on the current event.
//   Re-match requires a new rising edge of match.
// TESTING  (RING_SECS=3, SNOOZE_MIN=1, TONE_DIV=4)
// - Reset with all BCD=0 and alarm_en=1 -> no ringing.
//   Then cur 00:00->00:01 with alarm 00:01 -> ringing=1 one clk later.
// - Ring, no keys: 3 ticks -> ringing falls on the edge of the 3rd tick;
//   buzz toggles every 4 clks while ringing; buzz=0 after.
// - Ring, snooze pulse -> snoozing=1, buzz=0; after 60 ticks -> ringing=1 again;
//   then stop -> IDLE.
// - Stop and snooze in the same cycle during RING -> IDLE (stop wins);
//   minute unchanged -> no re-trigger.
// - alarm_en dropped mid-SNOOZE -> IDLE next edge; mid-RING rst_n pulse ->
//   all outputs 0 immediately.
// - Time moves to match with alarm_en=0, then alarm_en=1 in the same minute -> no ring.

Source files
------------

// File: rtl/alarm_ring.sv
// ---------------------------------------------------------------------------
// alarm_ring
// Alarm trigger and ring controller. Compares the running BCD time (hh:mm)
// against the stored alarm time. On a fresh match it rings the buzzer for a
// bounded number of seconds. A key press can stop the alarm or snooze it.
//
// Ports
//   clk          in   system clock, all state on rising edge
//   rst_n        in   asynchronous active-low reset
//   tick_1hz     in   one-clk pulse once per second
//   alarm_en     in   alarm armed (level)
//   cur_hour1/2  in   current hour digits, BCD
//   cur_min1/2   in   current minute digits, BCD
//   alm_hour1/2  in   alarm hour digits, BCD
//   alm_min1/2   in   alarm minute digits, BCD
//   stop         in   one-clk pulse: silence and disarm this event
//   snooze       in   one-clk pulse: pause ringing for SNOOZE_MIN minutes
//   ringing      out  high while ringing
//   snoozing     out  high while snoozing
//   buzz         out  square-wave tone while ringing, else 0
// ---------------------------------------------------------------------------
module alarm_ring #(
  parameter int RING_SECS  = 60,
  parameter int SNOOZE_MIN = 5,
  parameter int TONE_DIV   = 25000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_1hz,
  input  logic       alarm_en,
  input  logic [3:0] cur_hour1,
  input  logic [3:0] cur_hour2,
  input  logic [3:0] cur_min1,
  input  logic [3:0] cur_min2,
  input  logic [3:0] alm_hour1,
  input  logic [3:0] alm_hour2,
  input  logic [3:0] alm_min1,
  input  logic [3:0] alm_min2,
  input  logic       stop,
  input  logic       snooze,
  output logic       ringing,
  output logic       snoozing,
  output logic       buzz
);

  localparam int SNZ_TICKS = SNOOZE_MIN * 60;
  localparam int RW        = $clog2(RING_SECS + 1);
  localparam int SW        = $clog2(SNZ_TICKS + 1);
  localparam int TW        = $clog2(TONE_DIV + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RING   = 2'd1,
    SNOOZE = 2'd2
  } state_t;

  state_t          state_r;
  logic [RW-1:0]   ring_cnt_r;
  logic [SW-1:0]   snz_cnt_r;
  logic [TW-1:0]   tone_cnt_r;
  logic            buzz_r;
  logic            match_r;
  logic            match_s;
  logic            trigger_s;

  // Raw 4-bit digit compare; no BCD validity check is intended.
  assign match_s   = ({cur_hour1, cur_hour2, cur_min1, cur_min2} ==
                      {alm_hour1, alm_hour2, alm_min1, alm_min2});
  // Only a rising edge of match fires, so one trigger per matching minute.
  assign trigger_s = match_s & ~match_r & alarm_en;

  assign ringing  = (state_r == RING);
  assign snoozing = (state_r == SNOOZE);
  assign buzz     = buzz_r;

  // Ring/snooze state machine with its second, snooze and tone counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      ring_cnt_r <= '0;
      snz_cnt_r  <= '0;
      tone_cnt_r <= '0;
      buzz_r     <= 1'b0;
      // Starts high so 00:00 == 00:00 out of reset is not a new match.
      match_r    <= 1'b1;
    end else begin
      match_r <= match_s;
      if (!alarm_en) begin
        state_r    <= IDLE;
        ring_cnt_r <= '0;
        snz_cnt_r  <= '0;
        tone_cnt_r <= '0;
        buzz_r     <= 1'b0;
      end else begin
        case (state_r)
          IDLE: begin
            if (trigger_s) begin
              state_r    <= RING;
              ring_cnt_r <= '0;
              tone_cnt_r <= '0;
              buzz_r     <= 1'b0;
            end
          end
          RING: begin
            if (stop) begin
              state_r    <= IDLE;
              ring_cnt_r <= '0;
              tone_cnt_r <= '0;
              buzz_r     <= 1'b0;
            end else if (snooze) begin
              state_r    <= SNOOZE;
              snz_cnt_r  <= SW'(SNZ_TICKS);
              ring_cnt_r <= '0;
              tone_cnt_r <= '0;
              buzz_r     <= 1'b0;
            end else if (tick_1hz && (ring_cnt_r == RW'(RING_SECS - 1))) begin
              // Last second of ringing elapsed: auto-off.
              state_r    <= IDLE;
              ring_cnt_r <= '0;
              tone_cnt_r <= '0;
              buzz_r     <= 1'b0;
            end else begin
              if (tick_1hz) begin
                ring_cnt_r <= ring_cnt_r + RW'(1);
              end
              // Half-period divider: toggle and wrap on the last count.
              if (tone_cnt_r == TW'(TONE_DIV - 1)) begin
                tone_cnt_r <= '0;
                buzz_r     <= ~buzz_r;
              end else begin
                tone_cnt_r <= tone_cnt_r + TW'(1);
              end
            end
          end
          SNOOZE: begin
            if (stop) begin
              state_r   <= IDLE;
              snz_cnt_r <= '0;
            end else if (tick_1hz) begin
              if (snz_cnt_r == SW'(1)) begin
                state_r    <= RING;
                snz_cnt_r  <= '0;
                ring_cnt_r <= '0;
                tone_cnt_r <= '0;
                buzz_r     <= 1'b0;
              end else begin
                snz_cnt_r <= snz_cnt_r - SW'(1);
              end
            end
          end
          default: begin
            state_r    <= IDLE;
            ring_cnt_r <= '0;
            snz_cnt_r  <= '0;
            tone_cnt_r <= '0;
            buzz_r     <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alarm_ring.sv
// ---------------------------------------------------------------------------
// tb_alarm_ring
// Self-checking bench for alarm_ring (RING_SECS=3, SNOOZE_MIN=1, TONE_DIV=4).
// Directed vector table, hand sequences for multi-cycle corners, and a
// randomized run against a behavioural model.
// ---------------------------------------------------------------------------
module tb_alarm_ring;

  localparam int RING_SECS  = 3;
  localparam int SNOOZE_MIN = 1;
  localparam int TONE_DIV   = 4;

  logic        clk;
  logic        rst_n;
  logic        tick_1hz;
  logic        alarm_en;
  logic [15:0] cur_t;
  logic [15:0] alm_t;
  logic        stop;
  logic        snooze;
  logic        ringing;
  logic        snoozing;
  logic        buzz;

  int checks;
  int failures;

  // behavioural model: 0 idle, 1 ring, 2 snooze
  int m_mode;
  int m_ring_ticks;
  int m_ring_cycles;
  int m_snz_ticks;
  bit m_prev_match;

  typedef struct {
    logic [15:0] cur;
    logic [15:0] alm;
    logic        en;
    logic        tick;
    logic        stp;
    logic        snz;
    logic [2:0]  exp;   // {ringing, snoozing, buzz}
  } vec_t;

  vec_t vecs[10];

  alarm_ring #(
    .RING_SECS (RING_SECS),
    .SNOOZE_MIN(SNOOZE_MIN),
    .TONE_DIV  (TONE_DIV)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick_1hz (tick_1hz),
    .alarm_en (alarm_en),
    .cur_hour1(cur_t[15:12]),
    .cur_hour2(cur_t[11:8]),
    .cur_min1 (cur_t[7:4]),
    .cur_min2 (cur_t[3:0]),
    .alm_hour1(alm_t[15:12]),
    .alm_hour2(alm_t[11:8]),
    .alm_min1 (alm_t[7:4]),
    .alm_min2 (alm_t[3:0]),
    .stop     (stop),
    .snooze   (snooze),
    .ringing  (ringing),
    .snoozing (snoozing),
    .buzz     (buzz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got {ring,snz,buzz}=%b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode        = 0;
    m_ring_ticks  = 0;
    m_ring_cycles = 0;
    m_snz_ticks   = 0;
    m_prev_match  = 1'b1;
  endtask

  function automatic logic [2:0] model_out();
    logic b;
    b = (m_mode == 1) ? (((m_ring_cycles / TONE_DIV) % 2) == 1) : 1'b0;
    return {m_mode == 1, m_mode == 2, b};
  endfunction

  // Advance the model by one clock using the inputs seen at this edge.
  task automatic model_step();
    bit mt;
    bit trig;
    mt   = (cur_t == alm_t);
    trig = mt && !m_prev_match && alarm_en;
    if (!alarm_en) begin
      m_mode = 0;
    end else begin
      case (m_mode)
        0: if (trig) begin
          m_mode = 1; m_ring_ticks = 0; m_ring_cycles = 0;
        end
        1: begin
          if (stop) m_mode = 0;
          else if (snooze) begin
            m_mode = 2; m_snz_ticks = 0;
          end else begin
            m_ring_cycles++;
            if (tick_1hz) begin
              m_ring_ticks++;
              if (m_ring_ticks == RING_SECS) m_mode = 0;
            end
          end
        end
        default: begin
          if (stop) m_mode = 0;
          else if (tick_1hz) begin
            m_snz_ticks++;
            if (m_snz_ticks == SNOOZE_MIN * 60) begin
              m_mode = 1; m_ring_ticks = 0; m_ring_cycles = 0;
            end
          end
        end
      endcase
    end
    m_prev_match = mt;
  endtask

  // One clock: model advances at the edge, outputs compared 1 ns later.
  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    chk("model", {ringing, snoozing, buzz}, model_out());
  endtask

  task automatic pulse_tick();
    tick_1hz = 1'b1; cyc(); tick_1hz = 1'b0;
  endtask

  task automatic arm_ring(input logic [15:0] t);
    cur_t = 16'h0959; alm_t = t; cyc();
    cur_t = t; cyc();
    chk("arm_ring", {ringing, snoozing, buzz}, 3'b100);
  endtask

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0; tick_1hz = 1'b0; alarm_en = 1'b1;
    cur_t = 16'h0000; alm_t = 16'h0000; stop = 1'b0; snooze = 1'b0;
    model_reset();

    vecs[0] = '{16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000}; // no spurious ring
    vecs[1] = '{16'h0000, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000};
    vecs[2] = '{16'h0001, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0, 3'b100}; // trigger
    vecs[3] = '{16'h0001, 16'h0001, 1'b1, 1'b1, 1'b0, 1'b0, 3'b100}; // tick 1
    vecs[4] = '{16'h0001, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0, 3'b100};
    vecs[5] = '{16'h0001, 16'h0001, 1'b1, 1'b1, 1'b0, 1'b0, 3'b100}; // tick 2
    vecs[6] = '{16'h0001, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0, 3'b101}; // 4th clk: toggle
    vecs[7] = '{16'h0001, 16'h0001, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000}; // tick 3: off
    vecs[8] = '{16'h0001, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000}; // no re-trigger
    vecs[9] = '{16'h0001, 16'h0001, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", {ringing, snoozing, buzz}, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      cur_t = vecs[i].cur; alm_t = vecs[i].alm; alarm_en = vecs[i].en;
      tick_1hz = vecs[i].tick; stop = vecs[i].stp; snooze = vecs[i].snz;
      cyc();
      chk($sformatf("vec%0d", i), {ringing, snoozing, buzz}, vecs[i].exp);
    end
    tick_1hz = 1'b0; stop = 1'b0; snooze = 1'b0;

    // Snooze for 60 ticks, ring again, then stop.
    arm_ring(16'h0002);
    snooze = 1'b1; cyc(); snooze = 1'b0;
    chk("snooze_entry", {ringing, snoozing, buzz}, 3'b010);
    for (int i = 0; i < 59; i++) begin
      pulse_tick(); cyc();
    end
    chk("snooze_59", {ringing, snoozing, buzz}, 3'b010);
    pulse_tick();
    chk("snooze_60", {ringing, snoozing, buzz}, 3'b100);
    stop = 1'b1; cyc(); stop = 1'b0;
    chk("stop_after_snooze", {ringing, snoozing, buzz}, 3'b000);

    // Stop and snooze together: stop wins, same minute does not re-trigger.
    arm_ring(16'h0003);
    cyc(); cyc();
    stop = 1'b1; snooze = 1'b1; cyc(); stop = 1'b0; snooze = 1'b0;
    chk("stop_wins", {ringing, snoozing, buzz}, 3'b000);
    repeat (5) cyc();
    chk("no_retrigger", {ringing, snoozing, buzz}, 3'b000);

    // alarm_en dropped during snooze.
    arm_ring(16'h0004);
    snooze = 1'b1; cyc(); snooze = 1'b0;
    cyc(); cyc();
    alarm_en = 1'b0; cyc();
    chk("en_low_snooze", {ringing, snoozing, buzz}, 3'b000);
    alarm_en = 1'b1; cyc();

    // Async reset while ringing clears outputs without a clock edge.
    arm_ring(16'h0005);
    repeat (5) cyc();
    #2 rst_n = 1'b0;
    #1 chk("async_reset", {ringing, snoozing, buzz}, 3'b000);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cyc(); cyc();
    chk("post_reset_same_minute", {ringing, snoozing, buzz}, 3'b000);

    // Match reached while disarmed, then armed in the same minute.
    alarm_en = 1'b0; cur_t = 16'h1230; alm_t = 16'h1231; cyc();
    cur_t = 16'h1231; cyc();
    alarm_en = 1'b1;
    repeat (4) cyc();
    chk("arm_late_no_ring", {ringing, snoozing, buzz}, 3'b000);

    // Randomized run against the model.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 7) == 0) cur_t = 16'($urandom_range(0, 2));
      if ($urandom_range(0, 29) == 0) alm_t = 16'($urandom_range(0, 2));
      tick_1hz = ($urandom_range(0, 3) == 0);
      stop     = ($urandom_range(0, 59) == 0);
      snooze   = ($urandom_range(0, 19) == 0);
      alarm_en = ($urandom_range(0, 99) != 0);
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
